// File: rtl/kfps2kb_keycode_buffer_pkg.sv
// kfps2kb_pkg: shared types and constants for the XT keycode buffer.
// Holds the capture/presentation state encodings, the overrun marker
// value and the write-selection record produced by the top level.
package kfps2kb_pkg;

    localparam int unsigned KFPS2KB_CODE_W = 8;

    // Marker stored in the last free slot when the FIFO is about to overflow.
    localparam logic [KFPS2KB_CODE_W-1:0] KFPS2KB_OVERRUN_CODE = 8'hFF;

    // Upstream handshake: accept a code, then acknowledge it for one cycle.
    typedef enum logic {
        CAP_IDLE  = 1'b0,
        CAP_CLEAR = 1'b1
    } cap_state_e;

    // Host side: present head, wait for ack, force a one-cycle low gap.
    typedef enum logic [1:0] {
        PR_EMPTY   = 2'd0,
        PR_PRESENT = 2'd1,
        PR_GAP     = 2'd2
    } pr_state_e;

    // Outcome of an accepted upstream code: whether to store it and what.
    typedef struct packed {
        logic                      push;
        logic [KFPS2KB_CODE_W-1:0] data;
    } wr_sel_t;

endpackage

// File: rtl/kfps2kb_keycode_buffer_if.sv
// kfps2kb_keycode_buffer_if: groups the upstream handshake, host port and
// occupancy signals of the keycode buffer. The buffer connects through the
// slave modport; the surrounding system drives it through master.
interface kfps2kb_keycode_buffer_if #(
    parameter int DEPTH = 8
);

    // Upstream (PS/2 controller) side
    logic                     src_irq;
    logic [7:0]               src_keycode;
    logic                     src_clear;

    // Port-B "clear keyboard" control, active-high enable
    logic                     kbd_enable;

    // Host (PPI port A / PIC IRQ1) side
    logic                     host_irq;
    logic [7:0]               host_data;
    logic                     host_ack;

    // Current FIFO occupancy
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  src_irq,
        input  src_keycode,
        input  kbd_enable,
        input  host_ack,
        output src_clear,
        output host_irq,
        output host_data,
        output count
    );

    modport master (
        output src_irq,
        output src_keycode,
        output kbd_enable,
        output host_ack,
        input  src_clear,
        input  host_irq,
        input  host_data,
        input  count
    );

endinterface

// File: rtl/kfps2kb_keycode_buffer_sync_fifo.sv
// kfps2kb_sync_fifo: DEPTH x 8 synchronous FIFO with wrapping pointers and
// an occupancy counter that saturates at DEPTH. flush clears pointers and
// count and overrides push/pop. Storage itself is not reset; only the
// pointers and count are, so stale entries are never visible.
module kfps2kb_sync_fifo #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic [CNT_W-1:0] count
);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Next pointer/count values; a push into a full FIFO or a pop from an
    // empty one is dropped so the count can never leave 0..DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; a flush in the same cycle wins over the push.
    always_ff @(posedge clock) begin
        if (!flush && do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/kfps2kb_keycode_buffer.sv
// kfps2kb_keycode_buffer: queues translated XT keycodes from the PS/2
// controller and hands them to the PPI/PIC one at a time.
// Build option: define KFPS2KB_OVERRUN_CODE_EN to store an 0xFF overrun
// marker in the last free slot instead of a real code; without it the FIFO
// fills with real codes and anything beyond DEPTH is dropped.
module kfps2kb_keycode_buffer
    import kfps2kb_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input logic                      clock,
    input logic                      reset_n,
    kfps2kb_keycode_buffer_if.slave  bus
);

    cap_state_e       cap_state_q, cap_state_d;
    pr_state_e        pr_state_q, pr_state_d;
    logic             src_clear_q, src_clear_d;
    logic             host_irq_q, host_irq_d;
    logic [7:0]       host_data_q, host_data_d;
    logic             cap_accept;
    wr_sel_t          wr_sel;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;

    // Decide what an accepted code turns into, given occupancy before the edge.
    function automatic wr_sel_t select_write(input logic [CNT_W-1:0] occ,
                                             input logic [7:0]       code);
        wr_sel_t sel;
        sel.push = 1'b0;
        sel.data = code;
`ifdef KFPS2KB_OVERRUN_CODE_EN
        if (occ < CNT_W'(DEPTH - 1)) begin
            sel.push = 1'b1;
        end else if (occ == CNT_W'(DEPTH - 1)) begin
            sel.push = 1'b1;
            sel.data = KFPS2KB_OVERRUN_CODE;
        end
`else
        if (occ < CNT_W'(DEPTH)) begin
            sel.push = 1'b1;
        end
`endif
        return sel;
    endfunction

    // Capture FSM next state: accept in IDLE, acknowledge for one cycle.
    always_comb begin
        cap_state_d = cap_state_q;
        src_clear_d = 1'b0;
        cap_accept  = 1'b0;
        case (cap_state_q)
            CAP_IDLE: begin
                if (bus.src_irq) begin
                    cap_accept  = 1'b1;
                    src_clear_d = 1'b1;
                    cap_state_d = CAP_CLEAR;
                end
            end
            CAP_CLEAR: begin
                cap_state_d = CAP_IDLE;
            end
            default: begin
                cap_state_d = CAP_IDLE;
            end
        endcase
    end

    // Capture FSM state and registered acknowledge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cap_state_q <= CAP_IDLE;
            src_clear_q <= 1'b0;
        end else begin
            cap_state_q <= cap_state_d;
            src_clear_q <= src_clear_d;
        end
    end

    // Codes arriving while the keyboard is disabled are acknowledged only.
    assign wr_sel     = select_write(fifo_count, bus.src_keycode);
    assign fifo_push  = cap_accept && bus.kbd_enable && wr_sel.push;
    assign fifo_flush = !bus.kbd_enable;

    kfps2kb_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .din     (wr_sel.data),
        .dout    (fifo_dout),
        .count   (fifo_count)
    );

    // Presentation FSM next state: load head on entry to PRESENT, pop on
    // ack, then hold irq low for one cycle so the PIC sees a new edge.
    always_comb begin
        pr_state_d  = pr_state_q;
        host_irq_d  = host_irq_q;
        host_data_d = host_data_q;
        fifo_pop    = 1'b0;
        if (!bus.kbd_enable) begin
            pr_state_d  = PR_EMPTY;
            host_irq_d  = 1'b0;
            host_data_d = 8'h00;
        end else begin
            case (pr_state_q)
                PR_EMPTY: begin
                    if (fifo_count != '0) begin
                        pr_state_d  = PR_PRESENT;
                        host_irq_d  = 1'b1;
                        host_data_d = fifo_dout;
                    end
                end
                PR_PRESENT: begin
                    if (bus.host_ack) begin
                        fifo_pop   = 1'b1;
                        pr_state_d = PR_GAP;
                        host_irq_d = 1'b0;
                    end
                end
                PR_GAP: begin
                    if (fifo_count != '0) begin
                        pr_state_d  = PR_PRESENT;
                        host_irq_d  = 1'b1;
                        host_data_d = fifo_dout;
                    end else begin
                        pr_state_d  = PR_EMPTY;
                        host_irq_d  = 1'b0;
                    end
                end
                default: begin
                    pr_state_d = PR_EMPTY;
                    host_irq_d = 1'b0;
                end
            endcase
        end
    end

    // Presentation FSM state and registered host outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pr_state_q  <= PR_EMPTY;
            host_irq_q  <= 1'b0;
            host_data_q <= 8'h00;
        end else begin
            pr_state_q  <= pr_state_d;
            host_irq_q  <= host_irq_d;
            host_data_q <= host_data_d;
        end
    end

    assign bus.src_clear = src_clear_q;
    assign bus.host_irq  = host_irq_q;
    assign bus.host_data = host_data_q;
    assign bus.count     = fifo_count;

endmodule

// File: doc/kfps2kb_keycode_buffer.md
# kfps2kb_keycode_buffer

- **Position:** downstream of the PS/2 keyboard controller, in the XT keyboard path.
- **Upstream side:** takes each translated XT keycode from the controller's `irq`/`keycode` outputs and acknowledges it with a one-cycle `clear_keycode` pulse.
- **Storage:** queues codes in a small FIFO so back-to-back scancodes are not lost while software is slow.
- **Host side:** presents codes one at a time to the PPI port-A / PIC IRQ1 path.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, ≥4.
- `clock`  in  1: system clock; the only clock.
- `reset_n`  in  1: synchronous, active-low reset.
- `src_irq`  in  1: upstream keycode valid.
- `src_keycode`  in  8: upstream keycode.
- `src_clear`  out  1: one-cycle acknowledge to upstream `clear_keycode`.
- `kbd_enable`  in  1: low holds the buffer flushed (XT port-B bit 7 "clear keyboard").
- `host_irq`  out  1: code available (to PIC IRQ1).
- `host_data`  out  8: head keycode (to PPI port A).
- `host_ack`  in  1: one-cycle pulse; head consumed.
- `count`  out  $clog2(DEPTH)+1: current occupancy.

## Operation
- **Capture FSM, states CAP_IDLE and CAP_CLEAR:**
  - CAP_IDLE with `src_irq`=1 → accept the code at that edge, go to CAP_CLEAR.
  - CAP_CLEAR drives `src_clear`=1 for exactly one cycle, ignores `src_irq`, then returns to CAP_IDLE. Upstream drops `irq` on the same edge.
- **Accepting a code:**
  - count < DEPTH-1 → write `src_keycode`.
  - count == DEPTH-1 → write 0xFF (overrun marker) instead.
  - count == DEPTH → discard.
  - `src_clear` is pulsed in every case.
- **Presentation FSM, states PR_EMPTY, PR_PRESENT, PR_GAP:**
  - PR_EMPTY → PR_PRESENT when count>0. At that edge `host_data` loads the head and `host_irq` rises.
  - PR_PRESENT with `host_ack` → pop the head, go to PR_GAP. `host_irq`=0 and `host_data` is held.
  - PR_GAP lasts exactly one cycle, then goes to PR_PRESENT if count>0, else PR_EMPTY. This guarantees the edge-triggered PIC sees a fresh rising edge per code.
  - `host_ack` outside PR_PRESENT is ignored.
- **Simultaneous write and pop:** both take effect; count unchanged. The full/marker decision uses count before the edge.
- **Pointers:** read/write pointers wrap modulo DEPTH; count saturates at DEPTH.
- **`kbd_enable`=0:**
  - Pointers and count are cleared each cycle.
  - Presentation FSM forced to PR_EMPTY; `host_irq`=0, `host_data`=0x00.
  - Capture FSM keeps running: upstream codes are acknowledged and discarded.
- **Reset:** `reset_n`=0 dominates everything.
  - FSMs → CAP_IDLE and PR_EMPTY.
  - `src_clear`=0, `host_irq`=0, `host_data`=0x00, `count`=0.
  - Reset mid-handshake simply abandons the pending code.

## Timing
- `src_irq` high in cycle N → written at end of N; `src_clear` high in N+1 only.
- Next accept no earlier than cycle N+2; minimum 2 cycles per code.
- Empty FIFO, write at end of N → `host_irq`/`host_data` valid from N+2.
- `host_ack` in cycle M → `host_irq` low in M+1 (PR_GAP). Next code presented from M+2 at the earliest.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: `KFPS2KB_OVERRUN_CODE_EN`.
- **Defined:** overrun marker behaviour as above. At most DEPTH-1 real codes are stored, plus one 0xFF.
- **Undefined:** no marker. Codes are written while count < DEPTH and discarded when count == DEPTH; up to DEPTH real codes are stored.

## Structure
- **Package `kfps2kb_pkg`:** capture and presentation state enums, plus constant `KFPS2KB_OVERRUN_CODE` = 8'hFF.
- **Sub-module `kfps2kb_sync_fifo`:**
  - Parameterised DEPTH × 8 storage with pointers and count.
  - Ports: push, pop, flush, din, dout.
  - Same `clock` and `reset_n`.
- **Top level:** both FSMs and the overrun selection.

## Test plan
- **Single code:** `src_irq` with 0x1E for 2 cycles → `src_clear` pulse in cycle 2; `host_irq`=1 and `host_data`=0x1E from cycle 3; `host_ack` → `host_irq` low one cycle, count 0.
- **Overrun, macro on, DEPTH=8:** push 0x01..0x09 with no acks → FIFO holds 0x01..0x07 then 0xFF; 0x09 discarded; 9 `src_clear` pulses; 8 acks drain in order.
- **Macro off, same stimulus:** holds 0x01..0x08; 0x09 discarded.
- **Back-to-back ack:** 3 queued codes, `host_ack` asserted every cycle `host_irq` is high → each code delivered once, one-cycle low gap between each, no skipped code.
- **Simultaneous push and pop at count=4:** count stays 4, order preserved.
- **Flush and reset:** `kbd_enable`=0 with 5 queued codes → count 0, `host_irq` 0, upstream code 0x2A still acknowledged. Separately, `reset_n`=0 during CAP_CLEAR → all outputs at reset values next cycle.
